spi_slave_bus_bridge: RTL and testbench

- SPI slave front end that turns frames from an external SPI master into single-cycle accesses on the 16-bit sys register bus (sys_sel / sys_wr_en / sys_rd_en / sys_waddr / sys_wdata / sys_raddr / sys_rdata).
- It is the responder counterpart of the team's SPI master. It lets an external host program any sys-bus register map.
- All SPI pins are oversampled in sys_clk; there is no SPI clock domain.
- Protocol: mode 0 (CPOL=0, CPHA=0), MSB first, with address auto-increment while CS is held.

---
 rtl/spi_slave_bus_bridge.sv | 160 ++++++++++++++++
 tb/tb_spi_slave_bus_bridge.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_bus_bridge.sv
// spi_slave_bus_bridge: oversampled mode-0 SPI slave that turns host frames into sys register bus accesses
module spi_slave_bus_bridge #(
    parameter int RD_LATENCY    = 1,
    parameter bit CS_ACTIVE_LOW = 1'b1
) (
    input  logic        sys_rst_n,
    input  logic        sys_clk,
    input  logic        spi_csn,
    input  logic        spi_sclk,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_en,
    output logic        sys_sel,
    output logic        sys_wr_en,
    output logic        sys_rd_en,
    output logic [7:0]  sys_waddr,
    output logic [15:0] sys_wdata,
    output logic [7:0]  sys_raddr,
    input  logic [15:0] sys_rdata,
    output logic        sys_busy,
    output logic        sys_frame_err
);
    typedef enum logic [2:0] {IDLE, INSTR, WR_DATA, RD_ADDR, RD_WAIT, RD_DATA} state_t;
    state_t      state, state_nx;
    logic [2:0]  csn_q, sclk_q, sdi_q;
    logic [3:0]  cnt, cnt_nx;
    logic [7:0]  addr, addr_nx, waddr_nx, raddr_nx;
    logic [14:0] rx, rx_nx;
    logic [15:0] tx, tx_nx, wdata_nx;
    logic [2:0]  lat, lat_nx;
    logic        loaded, loaded_nx, sel_nx, wr_nx, rd_nx, err_nx;
    logic        cs_act, cs_prev, cs_rise, cs_fall, sclk_rise, sclk_fall, sdi;

    assign cs_act     = csn_q[1] ~^ ~CS_ACTIVE_LOW;
    assign cs_prev    = csn_q[2] ~^ ~CS_ACTIVE_LOW;
    assign cs_rise    = cs_act & ~cs_prev;
    assign cs_fall    = ~cs_act & cs_prev;
    assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall  = ~sclk_q[1] & sclk_q[2];
    assign sdi        = sdi_q[2];
    assign sys_busy   = state != IDLE;
    assign spi_sdo_en = loaded && (state == RD_WAIT || state == RD_DATA);
    assign spi_sdo    = spi_sdo_en & tx[15];

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            csn_q         <= '0;
            sclk_q        <= '0;
            sdi_q         <= '0;
            state         <= IDLE;
            cnt           <= '0;
            addr          <= '0;
            rx            <= '0;
            tx            <= '0;
            lat           <= '0;
            loaded        <= 1'b0;
            sys_sel       <= 1'b0;
            sys_wr_en     <= 1'b0;
            sys_rd_en     <= 1'b0;
            sys_waddr     <= '0;
            sys_wdata     <= '0;
            sys_raddr     <= '0;
            sys_frame_err <= 1'b0;
        end else begin
            csn_q         <= {csn_q[1:0], spi_csn};
            sclk_q        <= {sclk_q[1:0], spi_sclk};
            sdi_q         <= {sdi_q[1:0], spi_sdi};
            state         <= state_nx;
            cnt           <= cnt_nx;
            addr          <= addr_nx;
            rx            <= rx_nx;
            tx            <= tx_nx;
            lat           <= lat_nx;
            loaded        <= loaded_nx;
            sys_sel       <= sel_nx;
            sys_wr_en     <= wr_nx;
            sys_rd_en     <= rd_nx;
            sys_waddr     <= waddr_nx;
            sys_wdata     <= wdata_nx;
            sys_raddr     <= raddr_nx;
            sys_frame_err <= err_nx;
        end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        addr_nx   = addr;
        rx_nx     = rx;
        tx_nx     = tx;
        lat_nx    = lat;
        loaded_nx = loaded;
        sel_nx    = 1'b0;
        wr_nx     = 1'b0;
        rd_nx     = 1'b0;
        err_nx    = 1'b0;
        waddr_nx  = sys_waddr;
        wdata_nx  = sys_wdata;
        raddr_nx  = sys_raddr;
        if (cs_fall) begin
            state_nx  = IDLE;
            loaded_nx = 1'b0;
            err_nx    = (state inside {INSTR, WR_DATA, RD_DATA}) && cnt != 4'd0;
        end else
            case (state)
                IDLE:
                    if (cs_rise) begin
                        state_nx = INSTR;
                        cnt_nx   = 4'd0;
                    end
                INSTR:
                    if (sclk_rise) begin
                        rx_nx  = {rx[13:0], sdi};
                        cnt_nx = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_nx   = 4'd0;
                            addr_nx  = {1'b0, rx[5:0], sdi};
                            state_nx = rx[6] ? RD_ADDR : WR_DATA;
                        end
                    end
                WR_DATA:
                    if (sclk_rise) begin
                        rx_nx  = {rx[13:0], sdi};
                        cnt_nx = cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            sel_nx   = 1'b1;
                            wr_nx    = 1'b1;
                            waddr_nx = addr;
                            wdata_nx = {rx, sdi};
                            addr_nx  = addr + 8'd1;
                        end
                    end
                RD_ADDR: begin
                    sel_nx   = 1'b1;
                    rd_nx    = 1'b1;
                    raddr_nx = addr;
                    lat_nx   = 3'd0;
                    state_nx = RD_WAIT;
                end
                RD_WAIT:
                    if (lat == 3'(RD_LATENCY)) begin
                        tx_nx     = sys_rdata;
                        loaded_nx = 1'b1;
                        state_nx  = RD_DATA;
                    end else
                        lat_nx = lat + 3'd1;
                RD_DATA: begin
                    if (sclk_fall && cnt != 4'd0)
                        tx_nx = {tx[14:0], 1'b0};
                    if (sclk_rise) begin
                        cnt_nx = cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            addr_nx  = addr + 8'd1;
                            state_nx = RD_ADDR;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
    end
endmodule

// File: tb/tb_spi_slave_bus_bridge.sv
// tb_spi_slave_bus_bridge: directed SPI-master frames against two bridges (read latency 1 and 3)
module tb_spi_slave_bus_bridge;
    localparam int HALF = 16;

    typedef struct {
        logic [7:0]  instr;
        logic [15:0] data;
        bit          quick;
        int          exp_wr;
        int          exp_rd;
        logic [7:0]  exp_addr;
        logic [15:0] exp_val;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0, csn = 1'b1, sclk = 1'b0, sdi = 1'b0;
    logic        sdo, sdo_en, sel, wr_en, rd_en, busy, ferr;
    logic [7:0]  waddr, raddr;
    logic [15:0] wdata, rdata = '0;
    logic        sdo3, sdo_en3, sel3, wr_en3, rd_en3, busy3, ferr3;
    logic [7:0]  waddr3, raddr3;
    logic [15:0] wdata3, rdata3 = '0, p1 = '0, p2 = '0;

    int          n_cmp = 0, n_bad = 0, wr_n = 0, err_n = 0, viol = 0;
    logic [7:0]  waddr_l = '0;
    logic [15:0] wdata_l = '0;
    logic [7:0]  ra_q[$], ra3_q[$];
    logic [39:0] miso, miso3, en;
    vec_t        vecs[7];

    always #5 clk = ~clk;

    spi_slave_bus_bridge #(.RD_LATENCY(1)) dut (
        .sys_rst_n(rst_n), .sys_clk(clk), .spi_csn(csn), .spi_sclk(sclk), .spi_sdi(sdi),
        .spi_sdo(sdo), .spi_sdo_en(sdo_en), .sys_sel(sel), .sys_wr_en(wr_en), .sys_rd_en(rd_en),
        .sys_waddr(waddr), .sys_wdata(wdata), .sys_raddr(raddr), .sys_rdata(rdata),
        .sys_busy(busy), .sys_frame_err(ferr)
    );

    spi_slave_bus_bridge #(.RD_LATENCY(3)) dut3 (
        .sys_rst_n(rst_n), .sys_clk(clk), .spi_csn(csn), .spi_sclk(sclk), .spi_sdi(sdi),
        .spi_sdo(sdo3), .spi_sdo_en(sdo_en3), .sys_sel(sel3), .sys_wr_en(wr_en3), .sys_rd_en(rd_en3),
        .sys_waddr(waddr3), .sys_wdata(wdata3), .sys_raddr(raddr3), .sys_rdata(rdata3),
        .sys_busy(busy3), .sys_frame_err(ferr3)
    );

    function automatic logic [15:0] model(input logic [7:0] a);
        case (a)
            8'h05:   return 16'h1234;
            8'h02:   return 16'hBEEF;
            8'h03:   return 16'h0F0F;
            default: return {8'hC0, a};
        endcase
    endfunction

    // Register targets: one-cycle and three-cycle read pipelines
    always @(posedge clk) begin
        if (rd_en) rdata <= model(raddr);
        if (rd_en3) p1 <= model(raddr3);
        p2     <= p1;
        rdata3 <= p2;
    end

    always @(negedge clk) begin
        if (wr_en) begin
            wr_n++;
            waddr_l = waddr;
            wdata_l = wdata;
        end
        if (rd_en) ra_q.push_back(raddr);
        if (rd_en3) ra3_q.push_back(raddr3);
        if (ferr) err_n++;
        if ((wr_en && rd_en) || sel != (wr_en | rd_en) || (!sdo_en && sdo)) viol++;
        if ((wr_en3 && rd_en3) || sel3 != (wr_en3 | rd_en3) || (!sdo_en3 && sdo3)) viol++;
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bit_rise(input logic b);
        sdi = b;
        cyc(HALF);
        miso  = {miso[38:0], sdo};
        miso3 = {miso3[38:0], sdo3};
        en    = {en[38:0], sdo_en};
        sclk  = 1'b1;
    endtask

    task automatic bit_xfer(input logic b);
        bit_rise(b);
        cyc(HALF);
        sclk = 1'b0;
    endtask

    // quick: release CS one cycle after the last rise, before the bridge can issue a follow-on read
    task automatic frame(input int nbits, input logic [39:0] mosi, input bit quick);
        miso  = '0;
        miso3 = '0;
        en    = '0;
        csn   = 1'b0;
        cyc(HALF);
        for (int i = nbits - 1; i >= 1; i--) bit_xfer(mosi[i]);
        bit_rise(mosi[0]);
        if (quick) begin
            cyc(1);
            csn = 1'b1;
            cyc(HALF);
            sclk = 1'b0;
            cyc(HALF);
        end else begin
            cyc(HALF);
            sclk = 1'b0;
            cyc(HALF);
            csn = 1'b1;
            cyc(HALF);
        end
    endtask

    initial begin
        int w0, r0, e0, r30;
        vecs[0] = '{8'h05, 16'hA5C3, 1'b0, 1, 0, 8'h05, 16'hA5C3};
        vecs[1] = '{8'h85, 16'h0000, 1'b1, 0, 1, 8'h05, 16'h1234};
        vecs[2] = '{8'h7F, 16'hFFFF, 1'b1, 1, 0, 8'h7F, 16'hFFFF};
        vecs[3] = '{8'h00, 16'h0001, 1'b0, 1, 0, 8'h00, 16'h0001};
        vecs[4] = '{8'hFF, 16'h0000, 1'b0, 0, 2, 8'h7F, 16'hC07F};
        vecs[5] = '{8'h83, 16'h0000, 1'b1, 0, 1, 8'h03, 16'h0F0F};
        vecs[6] = '{8'h2A, 16'h5A5A, 1'b0, 1, 0, 8'h2A, 16'h5A5A};

        cyc(3);
        check("reset_ctrl", {33'd0, sel, wr_en, rd_en, busy, sdo_en, sdo, ferr}, '0);
        check("reset_bus", {waddr, raddr, wdata}, '0);
        rst_n = 1'b1;
        cyc(8);

        foreach (vecs[k]) begin
            w0 = wr_n;
            r0 = ra_q.size();
            e0 = err_n;
            frame(24, {16'h0, vecs[k].instr, vecs[k].data}, vecs[k].quick);
            check($sformatf("v%0d_wr_cnt", k), wr_n - w0, vecs[k].exp_wr);
            check($sformatf("v%0d_rd_cnt", k), ra_q.size() - r0, vecs[k].exp_rd);
            check($sformatf("v%0d_err", k), err_n - e0, 0);
            check($sformatf("v%0d_busy", k), busy, 1'b0);
            if (vecs[k].exp_wr != 0) begin
                check($sformatf("v%0d_waddr", k), waddr_l, vecs[k].exp_addr);
                check($sformatf("v%0d_wdata", k), wdata_l, vecs[k].exp_val);
            end
            if (vecs[k].exp_rd != 0) begin
                check($sformatf("v%0d_raddr", k), ra_q.size() > r0 ? ra_q[r0] : 8'hxx, vecs[k].exp_addr);
                check($sformatf("v%0d_miso", k), miso[15:0], vecs[k].exp_val);
                check($sformatf("v%0d_sdo_en", k), en[23:0], 24'h00FFFF);
            end
            if (vecs[k].exp_rd == 2)
                check($sformatf("v%0d_raddr_next", k), ra_q.size() > r0 + 1 ? ra_q[r0 + 1] : 8'hxx, vecs[k].exp_addr + 8'd1);
        end

        w0 = wr_n;
        e0 = err_n;
        frame(40, {8'h10, 16'h1111, 16'h2222}, 1'b0);
        check("stream_wr_cnt", wr_n - w0, 2);
        check("stream_wr_last", {waddr_l, wdata_l}, {8'h11, 16'h2222});
        check("stream_wr_err", err_n - e0, 0);

        r0  = ra_q.size();
        r30 = ra3_q.size();
        frame(40, {8'h82, 32'h0}, 1'b0);
        check("stream_rd3_miso", miso3[31:0], 32'hBEEF0F0F);
        check("stream_rd1_miso", miso[31:0], 32'hBEEF0F0F);
        check("stream_rd_sdo_en", en[39:0], 40'h00FFFFFFFF);
        check("stream_rd3_cnt", ra3_q.size() - r30, 3);
        if (ra3_q.size() - r30 == 3)
            check("stream_rd3_addrs", {ra3_q[r30], ra3_q[r30 + 1], ra3_q[r30 + 2]}, 24'h020304);
        check("stream_rd1_cnt", ra_q.size() - r0, 3);

        w0 = wr_n;
        e0 = err_n;
        frame(20, {20'h0, 8'h01, 12'hABC}, 1'b0);
        check("abort_err", err_n - e0, 1);
        check("abort_wr", wr_n - w0, 0);
        check("abort_busy", busy, 1'b0);

        csn = 1'b0;
        cyc(HALF);
        for (int i = 7; i >= 0; i--) bit_xfer(8'h85 >> i);
        for (int i = 0; i < 5; i++) bit_xfer(1'b0);
        cyc(HALF / 2);
        check("pre_rst_active", {busy, sdo_en}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {sdo_en, sel, busy, rd_en, wr_en}, '0);
        cyc(3);
        rst_n = 1'b1;
        w0 = wr_n;
        e0 = err_n;
        cyc(HALF / 2);
        sclk = 1'b1;
        cyc(HALF);
        sclk = 1'b0;
        for (int i = 0; i < 10; i++) bit_xfer(1'b1);
        check("post_rst_idle", busy, 1'b0);
        cyc(HALF);
        csn = 1'b1;
        cyc(HALF);
        check("post_rst_quiet", {err_n - e0, wr_n - w0}, '0);
        w0 = wr_n;
        frame(24, {16'h0, 8'h07, 16'h0001}, 1'b0);
        check("post_rst_wr_cnt", wr_n - w0, 1);
        check("post_rst_wr", {waddr_l, wdata_l}, {8'h07, 16'h0001});

        check("bus_rules", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
